// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: pipelined multi-channel multiply-accumulate engine for the CNN
// convolution datapath. Each accepted KxK window (unsigned pixels, signed
// weights) is reduced to one dot-product. NUM_CHANNELS consecutive windows are
// summed into one signed result.
// Optional build macro: CONV_MAC_RELU_EN clamps negative results to zero at the
// output register. The accumulator itself keeps the signed value.
module conv_mac_pipe #(
  parameter int KERNEL_SIZE  = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int ACC_WIDTH    = 2*DATA_WIDTH + $clog2(KERNEL_SIZE*KERNEL_SIZE)
                               + $clog2(NUM_CHANNELS) + 1,
  localparam int CIDX_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic        [DATA_WIDTH-1:0] feature [KERNEL_SIZE][KERNEL_SIZE],
  input  logic signed [DATA_WIDTH-1:0] kernel  [KERNEL_SIZE][KERNEL_SIZE],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  result,
  output logic        [CIDX_W-1:0]     chan_idx
);

  localparam int NTAP   = KERNEL_SIZE*KERNEL_SIZE;
  localparam int PROD_W = 2*DATA_WIDTH;
  // Tree leaves are padded to a power of two so every level pairs up evenly.
  localparam int NPAD   = 1 << $clog2(NTAP);
  localparam int NNODE  = 2*NPAD - 1;
  localparam logic [CIDX_W-1:0] LAST_CH = CIDX_W'(NUM_CHANNELS - 1);

  // Output-stage clamp. With the macro undefined it passes the raw sum through.
  function automatic logic signed [ACC_WIDTH-1:0] relu_clip(
    input logic signed [ACC_WIDTH-1:0] v
  );
`ifdef CONV_MAC_RELU_EN
    relu_clip = v[ACC_WIDTH-1] ? '0 : v;
`else
    relu_clip = v;
`endif
  endfunction

  logic                        stall;
  logic                        accept;

  logic signed [PROD_W-1:0]    prod_p1_d [NTAP];
  logic signed [PROD_W-1:0]    prod_p1_q [NTAP];
  logic                        vld_p1_d, vld_p1_q;

  logic signed [ACC_WIDTH-1:0] tree_sum;
  logic signed [ACC_WIDTH-1:0] sum_p2_q;
  logic                        vld_p2_d, vld_p2_q;

  logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [ACC_WIDTH-1:0] result_d, result_q;
  logic                        out_valid_d, out_valid_q;
  logic        [CIDX_W-1:0]    chan_idx_d, chan_idx_q;
  logic                        advance, last_ch, land;

  // A result held for an unready consumer freezes the whole pipe.
  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = rst_n & ~stall & ~clear;
  assign accept   = in_valid & in_ready;

  // ---- S1: per-tap products (pixel zero-extended so it multiplies as signed)
  // Form all KxK products of the incoming window.
  always_comb begin
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      for (int c = 0; c < KERNEL_SIZE; c++) begin
        prod_p1_d[r*KERNEL_SIZE + c] =
          PROD_W'($signed({1'b0, feature[r][c]})) * PROD_W'(kernel[r][c]);
      end
    end
  end

  // S1 valid: flushed by clear, held during stall.
  always_comb begin
    vld_p1_d = vld_p1_q;
    if (clear)       vld_p1_d = 1'b0;
    else if (!stall) vld_p1_d = accept;
  end

  // S1 product registers. These are data only, loaded on an accepted window.
  always_ff @(posedge clk) begin
    if (accept) prod_p1_q <= prod_p1_d;
  end

  // ---- S2: balanced adder tree over the registered products
  // Heap-ordered reduction: node n sums children 2n+1 and 2n+2. Padding leaves are zero.
  always_comb begin
    logic signed [ACC_WIDTH-1:0] node [NNODE];
    for (int n = 0; n < NNODE; n++) node[n] = '0;
    for (int i = 0; i < NTAP; i++) node[NPAD-1+i] = ACC_WIDTH'(prod_p1_q[i]);
    for (int n = NPAD-2; n >= 0; n--) node[n] = node[2*n+1] + node[2*n+2];
    tree_sum = node[0];
  end

  // S2 valid: flushed by clear, held during stall.
  always_comb begin
    vld_p2_d = vld_p2_q;
    if (clear)       vld_p2_d = 1'b0;
    else if (!stall) vld_p2_d = vld_p1_q;
  end

  // S2 sum register. This is data only, loaded when a valid S1 entry advances.
  always_ff @(posedge clk) begin
    if (vld_p1_q && !stall) sum_p2_q <= tree_sum;
  end

  // ---- S3: channel accumulator and output register
  assign advance  = vld_p2_q & ~stall & ~clear;
  assign last_ch  = (chan_idx_q == LAST_CH);
  assign land     = advance & last_ch;
  assign acc_next = (chan_idx_q == '0) ? sum_p2_q : acc_q + sum_p2_q;

  // Accumulate and emit results. clear restarts the channel sum but leaves a pending result intact.
  always_comb begin
    acc_d       = acc_q;
    chan_idx_d  = chan_idx_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    if (clear) begin
      acc_d      = '0;
      chan_idx_d = '0;
    end else if (advance) begin
      acc_d      = acc_next;
      chan_idx_d = last_ch ? '0 : chan_idx_q + CIDX_W'(1);
    end
    if (!stall) out_valid_d = land;
    if (land)   result_d    = relu_clip(acc_next);
  end

  // Control and accumulator state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      acc_q       <= '0;
      chan_idx_q  <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      acc_q       <= acc_d;
      chan_idx_q  <= chan_idx_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign chan_idx  = chan_idx_q;

endmodule

// File: tb/tb_conv_mac_pipe.sv
// tb_conv_mac_pipe: directed bench for conv_mac_pipe. It instantiates four
// configurations: K3/C2, K3/C1, K5/C1 and K3/C4.
module tb_conv_mac_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic clear;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---- A: K=3, C=2
  logic              a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic        [7:0] a_feat [3][3];
  logic signed [7:0] a_kern [3][3];
  logic signed [21:0] a_result;
  logic        [0:0] a_chan;
  conv_mac_pipe #(.KERNEL_SIZE(3), .DATA_WIDTH(8), .NUM_CHANNELS(2)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .feature(a_feat), .kernel(a_kern), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .result(a_result), .chan_idx(a_chan));

  // ---- B: K=3, C=1
  logic              b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic        [7:0] b_feat [3][3];
  logic signed [7:0] b_kern [3][3];
  logic signed [20:0] b_result;
  logic        [0:0] b_chan;
  conv_mac_pipe #(.KERNEL_SIZE(3), .DATA_WIDTH(8), .NUM_CHANNELS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .feature(b_feat), .kernel(b_kern), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .result(b_result), .chan_idx(b_chan));

  // ---- C: K=5, C=1
  logic              c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic        [7:0] c_feat [5][5];
  logic signed [7:0] c_kern [5][5];
  logic signed [21:0] c_result;
  logic        [0:0] c_chan;
  conv_mac_pipe #(.KERNEL_SIZE(5), .DATA_WIDTH(8), .NUM_CHANNELS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .feature(c_feat), .kernel(c_kern), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .result(c_result), .chan_idx(c_chan));

  // ---- D: K=3, C=4
  logic              d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic        [7:0] d_feat [3][3];
  logic signed [7:0] d_kern [3][3];
  logic signed [22:0] d_result;
  logic        [1:0] d_chan;
  conv_mac_pipe #(.KERNEL_SIZE(3), .DATA_WIDTH(8), .NUM_CHANNELS(4)) u_d (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .feature(d_feat), .kernel(d_kern), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .result(d_result), .chan_idx(d_chan));

  // Result collectors: a transfer happens at the next rising edge when valid & ready.
  longint a_res[$];
  longint c_res[$];
  longint d_res[$];
  int     c_at[$];
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) a_res.push_back(a_result);
    if (rst_n && c_out_valid && c_out_ready) begin
      c_res.push_back(c_result);
      c_at.push_back(cyc);
    end
    if (rst_n && d_out_valid && d_out_ready) d_res.push_back(d_result);
  end

  longint exp_neg;
  int     acc_cnt;
  bit     first_seen;

  initial begin
`ifdef CONV_MAC_RELU_EN
    exp_neg = 0;
`else
    exp_neg = -293760;
`endif
    rst_n = 1'b0;
    clear = 1'b0;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0; d_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1; d_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        a_feat[i][j] = 8'd1;   a_kern[i][j] = 8'sd1;
        b_feat[i][j] = 8'd255; b_kern[i][j] = -8'sd128;
        d_feat[i][j] = 8'd1;   d_kern[i][j] = 8'sd1;
      end
    end
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        c_feat[i][j] = 8'(i*5 + j);
        c_kern[i][j] = 8'sd1;
      end
    end

    // Reset state
    tick; tick;
    check_val("rst_out_valid", a_out_valid, 0);
    check_val("rst_result", a_result, 0);
    check_val("rst_chan_idx", a_chan, 0);
    check_val("rst_in_ready", a_in_ready, 0);
    rst_n = 1'b1;
    tick;
    check_val("post_rst_in_ready", a_in_ready, 1);

    // T1: C=2, two all-ones windows back-to-back
    a_res.delete();
    a_in_valid = 1'b1;
    tick; tick;
    a_in_valid = 1'b0;
    check_val("t1_ov_e2", a_out_valid, 0);
    tick;
    check_val("t1_ov_e3", a_out_valid, 0);
    check_val("t1_chan_mid", a_chan, 1);
    tick;
    check_val("t1_ov_e4", a_out_valid, 1);
    check_val("t1_result", a_result, 18);
    check_val("t1_chan_wrap", a_chan, 0);
    tick;
    check_val("t1_ov_pulse_end", a_out_valid, 0);
    check_val("t1_count", a_res.size(), 1);

    // T2: C=1, large negative window then a small positive one
    b_in_valid = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) begin
      b_feat[i][j] = 8'd2; b_kern[i][j] = 8'sd3;
    end
    tick;
    b_in_valid = 1'b0;
    check_val("t2_ov_early", b_out_valid, 0);
    tick;
    check_val("t2_ov_neg", b_out_valid, 1);
    check_val("t2_result_neg", b_result, exp_neg);
    tick;
    check_val("t2_ov_pos", b_out_valid, 1);
    check_val("t2_result_pos", b_result, 54);
    tick;
    check_val("t2_ov_end", b_out_valid, 0);

    // T3: K=5, ramp pixels, 4 consecutive windows
    c_res.delete(); c_at.delete();
    c_in_valid = 1'b1;
    repeat (4) tick;
    c_in_valid = 1'b0;
    repeat (6) tick;
    check_val("t3_count", c_res.size(), 4);
    for (int i = 0; i < c_res.size(); i++) begin
      check_val($sformatf("t3_result%0d", i), c_res[i], 300);
      check_val($sformatf("t3_cycle%0d", i), c_at[i], c_at[0] + i);
    end

    // T4: C=2 continuous input with a 5-cycle output stall
    a_res.delete();
    acc_cnt = 0;
    first_seen = 1'b0;
    a_in_valid = 1'b1;
    for (int n = 0; n < 80 && acc_cnt < 12; n++) begin
      if (!first_seen && a_out_valid) begin
        first_seen = 1'b1;
        a_out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick;
          check_val($sformatf("t4_hold_result%0d", s), a_result, 18);
          check_val($sformatf("t4_hold_valid%0d", s), a_out_valid, 1);
          check_val($sformatf("t4_hold_in_ready%0d", s), a_in_ready, 0);
        end
        a_out_ready = 1'b1;
        #1;
      end
      if (a_in_ready) acc_cnt++;
      tick;
    end
    a_in_valid = 1'b0;
    repeat (10) tick;
    check_val("t4_accepts", acc_cnt, 12);
    check_val("t4_stall_seen", first_seen, 1);
    check_val("t4_count", a_res.size(), 6);
    for (int i = 0; i < a_res.size(); i++)
      check_val($sformatf("t4_result%0d", i), a_res[i], 18);

    // T5: C=4, two windows in flight flushed by clear, then four fresh windows
    d_res.delete();
    d_in_valid = 1'b1;
    tick; tick;
    clear = 1'b1;
    #1;
    check_val("t5_in_ready_clear", d_in_ready, 0);
    tick;
    clear = 1'b0;
    #1;
    check_val("t5_chan_after_clear", d_chan, 0);
    check_val("t5_in_ready_after", d_in_ready, 1);
    repeat (4) tick;
    d_in_valid = 1'b0;
    repeat (8) tick;
    check_val("t5_count", d_res.size(), 1);
    if (d_res.size() > 0) check_val("t5_result", d_res[0], 36);
    check_val("t5_chan_end", d_chan, 0);

    // T6: C=4, reset after three channels discards the partial sum
    d_res.delete();
    d_in_valid = 1'b1;
    repeat (3) tick;
    d_in_valid = 1'b0;
    repeat (3) tick;
    check_val("t6_chan_pre", d_chan, 3);
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_out_valid", d_out_valid, 0);
    check_val("t6_rst_result", d_result, 0);
    check_val("t6_rst_chan", d_chan, 0);
    check_val("t6_rst_in_ready", d_in_ready, 0);
    tick; tick;
    rst_n = 1'b1;
    #1;
    d_in_valid = 1'b1;
    repeat (4) tick;
    d_in_valid = 1'b0;
    repeat (8) tick;
    check_val("t6_count", d_res.size(), 1);
    if (d_res.size() > 0) check_val("t6_result", d_res[0], 36);
    check_val("t6_chan_end", d_chan, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
